fxp_power: RTL and testbench
============================

# fxp_power

Iterative fixed-point power unit: raises a Q10.10 base to an unsigned integer exponent 0–7 and returns a saturated Q10.10 result. It is the inverse of the team's nth-root unit and uses the same single-pulse `in_valid`/`out_valid` handshake. It is used to re-raise root results, for closed-loop checking and for downstream consumers that need x^n. It performs one multiply per cycle and terminates early on saturation.

## Interface
- `W`, 20: base/result width, Q10.10 (10 integer bits, 10 fraction bits)
- `FRAC`, 10: fraction bits
- `EW`, 3: exponent width

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  request strobe, sampled only in IDLE
- `in_data_1`  in  20  base, Q10.10 unsigned
- `in_data_2`  in  3  exponent n, 0–7
- `busy`  out  1  high whenever state ≠ IDLE (combinational from state)
- `out_valid`  out  1  one-cycle result strobe
- `out_data`  out  20  result, Q10.10; 0 when `out_valid`=0
- `out_ovf`  out  1  saturation flag, qualified by `out_valid`; 0 otherwise

## Operation
- States:
  - IDLE: wait for a request.
  - MUL: multiply loop.
  - DONE: present the result.
- Reset (async, immediate):
  - state=IDLE; `out_valid`, `out_data`, `out_ovf` = 0.
  - Internal `acc`, `base_r`, `cnt`, `sat` = 0.
- IDLE, `in_valid`=1 at an edge (capture edge):
  - `base_r`←`in_data_1`; `n_r`←`in_data_2`; `cnt`←1; `sat`←0.
  - `acc`←20'h00400 (1.0) if n=0, else `in_data_1`.
  - Next state: MUL if n≥2, else DONE.
- IDLE, `in_valid`=0: hold.
- MUL, each edge:
  - p = `acc`×`base_r` (40-bit); q = p>>10 (truncate toward zero, no rounding).
  - If p[39:30]≠0 (q exceeds 20'hFFFFF): `acc`←20'hFFFFF, `sat`←1, next state DONE (early exit).
  - Else `acc`←q[19:0], `cnt`←`cnt`+1; next state DONE when `cnt`+1 = `n_r`, else stay in MUL.
- DONE, one edge:
  - `out_valid`←1, `out_data`←`acc`, `out_ovf`←`sat`; next state IDLE.
- Any other edge: `out_valid`←0, `out_data`←0, `out_ovf`←0.
- `in_valid` while `busy`=1 is ignored. The request is not queued, and the inputs need not be held after the capture edge.
- Base 0 with n≥1 yields 0. Base 0 with n=0 yields 1.0 (0^0 = 1 by definition).
- Unsigned only; there is no negative handling.

## Timing
- Latency from capture edge to the edge that raises `out_valid`:
  - L = max(n,1) cycles without saturation.
  - On saturation at multiply k (k = 1..n−1): L = k+1.
- `out_valid` is high for exactly one cycle.
- `busy` falls on the same edge that raises `out_valid`.
- Back-to-back: a new request can be captured on the edge immediately after `out_valid` rises (`busy`=0 in that cycle). Throughput is one result per L+1 cycles.
- `in_valid` coincident with the DONE edge: ignored (state is not IDLE at that edge).
- Reset mid-operation: outputs clear asynchronously and the request is dropped. The first capture is possible on the first edge after `rst_n` is released.

## Structure
- Package `fxp_pkg`:
  - `Q_W`=20, `Q_FRAC`=10.
  - `Q_ONE`=20'h00400, `Q_MAX`=20'hFFFFF.
  - State enum {IDLE, MUL, DONE}.
  - Shared with the root unit.
- Sub-module `qmul_sat`: combinational Q10.10 × Q10.10 multiply with truncate-and-saturate; outputs `q[19:0]` and `ovf`. It is reusable by the root unit's power loop.
- Top: FSM, operand registers, exponent counter, output registers.

## Test plan
- Base 20'h00800 (2.0), n=3 → `out_data`=20'h02000 (8.0), `out_ovf`=0, `out_valid` 3 cycles after capture.
- Base 20'h00600 (1.5), n=2 → 20'h00900 (2.25). Base 20'h00401, n=2 → 20'h00402 (truncation, not rounding).
- n=0, base 20'h12345 → 20'h00400, latency 1. n=1, base 20'h12345 → 20'h12345, latency 1.
- Base 20'h40000 (256.0), n=3 → 20'hFFFFF, `out_ovf`=1, latency 2 (early exit at first multiply).
- `in_valid` held high for 20 cycles with base 20'h00800, n=2:
  - results 20'h01000 appear every 3 cycles;
  - no capture occurs while `busy`=1;
  - `out_data`=0 between pulses.
- Assert `rst_n`=0 during MUL (base 20'h00C00, n=7):
  - `out_valid`/`out_data`/`out_ovf` are 0 immediately;
  - no stale pulse appears after release;
  - a subsequent request (20'h00800, n=2) returns 20'h01000.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared Q10.10 constants and FSM state type for the power and root units.
package fxp_pkg;
    localparam int Q_W    = 20;
    localparam int Q_FRAC = 10;

    localparam logic [Q_W-1:0] Q_ONE = 20'h00400;
    localparam logic [Q_W-1:0] Q_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/qmul_sat.sv
// Combinational unsigned Q-format multiply: truncate the fraction, saturate on integer overflow.
module qmul_sat #(
    parameter int W    = 20,
    parameter int FRAC = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic         ovf
);
    logic [2*W-1:0] p;

    assign p   = a * b;
    // Any set bit above the retained window means the shifted product does not fit.
    assign ovf = |p[2*W-1:W+FRAC];
    assign q   = ovf ? {W{1'b1}} : p[W+FRAC-1:FRAC];
endmodule

// File: rtl/fxp_power.sv
// Iterative Q10.10 power unit: base^n for n in 0..7, one multiply per cycle, early exit on saturation.
module fxp_power
    import fxp_pkg::*;
#(
    parameter int W    = 20,
    parameter int FRAC = 10,
    parameter int EW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data_1,
    input  logic [EW-1:0] in_data_2,
    output logic          busy,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic          out_ovf
);
    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  base_r;
    logic [EW-1:0] n_r;
    logic [EW-1:0] cnt;
    logic          sat;

    logic [W-1:0]  mul_q;
    logic          mul_ovf;
    logic [EW:0]   cnt_nxt;

    qmul_sat #(.W(W), .FRAC(FRAC)) u_qmul (
        .a   (acc),
        .b   (base_r),
        .q   (mul_q),
        .ovf (mul_ovf)
    );

    // Extra bit keeps the loop-end compare exact at the top exponent.
    assign cnt_nxt = {1'b0, cnt} + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            base_r    <= '0;
            n_r       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base_r <= in_data_1;
                        n_r    <= in_data_2;
                        cnt    <= EW'(1);
                        sat    <= 1'b0;
                        // 0^0 is defined as 1.0, so n=0 bypasses the multiplier entirely.
                        acc    <= (in_data_2 == '0) ? W'(Q_ONE) : in_data_1;
                        state  <= (in_data_2 >= EW'(2)) ? MUL : DONE;
                    end
                end
                MUL: begin
                    if (mul_ovf) begin
                        acc   <= W'(Q_MAX);
                        sat   <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc <= mul_q;
                        cnt <= cnt_nxt[EW-1:0];
                        if (cnt_nxt == {1'b0, n_r})
                            state <= DONE;
                    end
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                    out_ovf   <= sat;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_power.sv
// Scoreboard bench for fxp_power: driver queues expected results, monitor checks each output pulse.
module tb_fxp_power;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] in_data_1 = '0;
    logic [2:0]  in_data_2 = '0;
    logic        busy;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ovf;

    typedef struct {
        logic [19:0] data;
        logic        ovf;
        int          lat;
        int          cap;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pulses = 0;

    fxp_power dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation, idle cycles must read zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got data %h ovf %b, expected no pulse", out_data, out_ovf);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_data"}, 32'(out_data), 32'(e.data));
                    chk({e.name, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
                    chk({e.name, "_lat"}, 32'(cyc - e.cap), 32'(e.lat));
                end
            end else begin
                chk("idle_out", {11'd0, out_ovf, out_data}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [19:0] b, input logic [2:0] n,
                         input logic [19:0] ed, input logic eo, input int lat, input string name);
        exp_t e;
        wait_idle();
        in_valid  = 1'b1;
        in_data_1 = b;
        in_data_2 = n;
        e.data = ed; e.ovf = eo; e.lat = lat; e.cap = cyc + 1; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p0;
        repeat (2) @(negedge clk);
        chk("reset_out", {10'd0, busy, out_valid, out_data}, 32'd0);
        chk("reset_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(20'h00800, 3'd3, 20'h02000, 1'b0, 3, "pow2_3");
        drain();
        issue(20'h00600, 3'd2, 20'h00900, 1'b0, 2, "pow1p5_2");
        issue(20'h00401, 3'd2, 20'h00402, 1'b0, 2, "trunc");
        issue(20'h12345, 3'd0, 20'h00400, 1'b0, 1, "n0");
        issue(20'h12345, 3'd1, 20'h12345, 1'b0, 1, "n1");
        issue(20'h00000, 3'd0, 20'h00400, 1'b0, 1, "zero_n0");
        issue(20'h00000, 3'd5, 20'h00000, 1'b0, 5, "zero_n5");
        issue(20'h40000, 3'd3, 20'hFFFFF, 1'b1, 2, "sat_early");
        issue(20'h00C00, 3'd7, 20'hFFFFF, 1'b1, 7, "sat_k6");
        issue(20'h00400, 3'd7, 20'h00400, 1'b0, 7, "one_n7");
        drain();

        // Held request: captures happen only when idle, one result every 3 cycles.
        p0 = pulses;
        in_valid  = 1'b1;
        in_data_1 = 20'h00800;
        in_data_2 = 3'd2;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                exp_t e;
                e.data = 20'h01000; e.ovf = 1'b0; e.lat = 2; e.cap = cyc + 1; e.name = "burst";
                sb.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        chk("burst_count", 32'(pulses - p0), 32'd7);

        // Reset in the middle of a long multiply loop drops the request.
        wait_idle();
        in_valid  = 1'b1;
        in_data_1 = 20'h00C00;
        in_data_2 = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out", {11'd0, out_valid, out_data}, 32'd0);
        chk("rst_ovf_busy", {out_ovf, busy}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (12) @(negedge clk);
        chk("no_stale_pulse", 32'(pulses - p0), 32'd0);
        issue(20'h00800, 3'd2, 20'h01000, 1'b0, 2, "after_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
